// File: rtl/pipelined_addsub_if.sv
// Operand and result streams of the pipelined adder/subtractor.
// The slave side is the arithmetic block, the master side is the producer/consumer.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CI;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;

  modport master (
    output in_valid, A, B, CI, SUB, out_ready,
    input  in_ready, out_valid, Y, C, V, Z, N
  );

  modport slave (
    input  in_valid, A, B, CI, SUB, out_ready,
    output in_ready, out_valid, Y, C, V, Z, N
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub with ALU flags; each stage resolves one
// CHUNK of the carry chain and forwards the rest of the operands.
module pipelined_addsub_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             c_i,
  input  logic             ov_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ov_o
);
  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] s_nxt;
  logic             ov_nxt;

  assign sum   = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + (CHUNK+1)'(c_i);
  assign s_nxt = (s_i & ~(WIDTH'({CHUNK{1'b1}}) << LO)) | (WIDTH'(sum[CHUNK-1:0]) << LO);
  // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ cin.
  assign ov_nxt = LAST ? (a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ s_nxt[WIDTH-1] ^ sum[CHUNK]) : ov_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_o <= 1'b0;
      a_o   <= '0;
      b_o   <= '0;
      s_o   <= '0;
      c_o   <= 1'b0;
      ov_o  <= 1'b0;
    end else if (load) begin
      vld_o <= vld_i;
      if (vld_i) begin
        a_o  <= a_i;
        b_o  <= b_i;
        s_o  <= s_nxt;
        c_o  <= sum[CHUNK];
        ov_o <= ov_nxt;
      end
    end
  end
endmodule

module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipelined_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            c_p;
  logic [STAGES:0]            ov_p;
  logic [STAGES:0][WIDTH-1:0] a_p;
  logic [STAGES:0][WIDTH-1:0] b_p;
  logic [STAGES:0][WIDTH-1:0] s_p;
  logic [STAGES-1:0]          load;

  assign vld_pipe[0] = bus.in_valid;
  assign a_p[0]      = bus.A;
  assign b_p[0]      = bus.B ^ {WIDTH{bus.SUB}};
  assign s_p[0]      = '0;
  assign c_p[0]      = bus.CI;
  assign ov_p[0]     = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // A stage can take new data if the consumer is ready or any later slot is a bubble.
    assign load[k] = bus.out_ready || !(&vld_pipe[STAGES:k+1]);

    pipelined_addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k),
      .LAST  (k == STAGES-1)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .vld_i (vld_pipe[k]),
      .a_i   (a_p[k]),
      .b_i   (b_p[k]),
      .s_i   (s_p[k]),
      .c_i   (c_p[k]),
      .ov_i  (ov_p[k]),
      .vld_o (vld_pipe[k+1]),
      .a_o   (a_p[k+1]),
      .b_o   (b_p[k+1]),
      .s_o   (s_p[k+1]),
      .c_o   (c_p[k+1]),
      .ov_o  (ov_p[k+1])
    );
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.Y         = s_p[STAGES];
  assign bus.C         = c_p[STAGES];
  assign bus.V         = ov_p[STAGES];
  assign bus.Z         = ~|s_p[STAGES];
  assign bus.N         = s_p[STAGES][WIDTH-1];
endmodule
